frame_buffer_clr: RTL
=====================

Name: frame_buffer_clr

Overview:
Parametrised single-clock dual-port frame buffer, successor to the 1-bit 32K-pixel VGA buffer. Port A is read/write for the CPU/drawing side; port B is read-only for the VGA scan-out side. Adds a hardware clear engine that fills the whole buffer with a programmable value, one word per cycle. Adds a read-valid strobe on port B, a parametrised read-during-write mode on port A, and out-of-range address handling.

Parameters:
DATA_WIDTH, 1, bits per word (pixel).
ADDR_WIDTH, 15, address bus width.
DEPTH, 2**ADDR_WIDTH, number of stored words; DEPTH <= 2**ADDR_WIDTH.
WRITE_FIRST, 0, port A read-during-write mode: 0 = A_DATA_OUT returns old data, 1 = A_DATA_OUT returns new data.

Ports:
CLK  in  1  single clock for both ports and the clear engine.
RESET  in  1  asynchronous, active-high reset.
A_ADDR  in  ADDR_WIDTH  port A address.
A_DATA_IN  in  DATA_WIDTH  port A write data.
A_WE  in  1  port A write enable.
A_EN  in  1  port A access enable (read or write).
A_DATA_OUT  out  DATA_WIDTH  port A read data, registered.
B_ADDR  in  ADDR_WIDTH  port B address.
B_EN  in  1  port B read enable.
B_DATA  out  DATA_WIDTH  port B read data, registered.
B_VALID  out  1  B_DATA is valid this cycle.
CLR_START  in  1  single-cycle pulse that starts a clear.
CLR_VALUE  in  DATA_WIDTH  fill value, sampled on the CLR_START cycle.
BUSY  out  1  clear in progress; port A is locked out.
CLR_DONE  out  1  one-cycle pulse after the last word is written.

Behaviour:
- Reset (asynchronous, RESET=1): A_DATA_OUT=0, B_DATA=0, B_VALID=0, BUSY=0, CLR_DONE=0. The clear counter and the latched fill value go to 0. Memory contents are not reset.
- Port A, with A_EN=1 and BUSY=0:
  - A_WE=1 writes A_DATA_IN at the clock edge.
  - A_DATA_OUT updates with 1-cycle latency: old word if WRITE_FIRST=0, written word if WRITE_FIRST=1.
  - A_WE=0 is a plain read with 1-cycle latency.
  - A_EN=0 holds A_DATA_OUT.
- Port B:
  - B_EN=1 registers mem[B_ADDR] into B_DATA next cycle and sets B_VALID=1.
  - B_EN=0 holds B_DATA and sets B_VALID=0.
  - Port B is always read-first against concurrent port A or clear writes to the same address: it returns the old word.
- Out-of-range address (addr >= DEPTH): writes are dropped and reads return 0. Port B still asserts B_VALID.
- Clear FSM states are IDLE and CLEAR.
  - IDLE: CLR_START=1 latches CLR_VALUE, sets counter=0 and BUSY=1, and moves to CLEAR the next cycle.
  - CLEAR: each cycle writes the fill value to mem[counter] and increments counter.
  - When counter = DEPTH-1 is written, the FSM returns to IDLE, BUSY falls on the next edge, and CLR_DONE pulses for exactly that one cycle.
  - A clear lasts DEPTH cycles of BUSY=1.
- While BUSY=1: port A writes are dropped and A_DATA_OUT holds. Port B operates normally and may return pre-clear or cleared data depending on address order.
- CLR_START while BUSY=1 is ignored and CLR_VALUE is not re-latched.
- CLR_START and A_EN&A_WE in the same IDLE cycle: the clear starts and the port A write is dropped.
- RESET during CLEAR aborts the clear: FSM returns to IDLE, BUSY=0, no CLR_DONE, memory is left partially cleared.
- The counter is ADDR_WIDTH bits wide and never wraps past DEPTH-1.

Test Plan:
1. DATA_WIDTH=8, ADDR_WIDTH=4, DEPTH=16. Write 0xA5 to A_ADDR=3, then read with B_EN=1, B_ADDR=3 -> B_DATA=0xA5 and B_VALID=1 exactly one cycle after B_EN. B_VALID=0 on the cycle after B_EN drops.
2. Same-address collision: mem[5]=0x11; port A writes 0x22 to address 5 while B reads address 5 in the same cycle -> B_DATA=0x11. With WRITE_FIRST=0, A_DATA_OUT=0x11; with WRITE_FIRST=1, A_DATA_OUT=0x22. A read of address 5 one cycle later returns 0x22 on both ports.
3. Clear: CLR_START with CLR_VALUE=0x3C -> BUSY=1 for 16 cycles, CLR_DONE high for exactly 1 cycle, then every address 0..15 reads 0x3C. An A_WE of 0x77 to address 2 during BUSY is dropped, so address 2 reads 0x3C.
4. Reset mid-clear: assert RESET on clear cycle 6 -> BUSY=0 and all outputs 0 immediately (asynchronous), no CLR_DONE. Addresses 0..5 read the fill value; addresses 6..15 keep their prior contents.
5. DEPTH=12 with ADDR_WIDTH=4: write 0xFF to address 13 -> dropped; B read of address 13 -> B_DATA=0, B_VALID=1. A clear takes 12 BUSY cycles.
6. CLR_START pulsed again on BUSY cycle 3 with CLR_VALUE=0x00 -> ignored: clear still ends after 16 cycles and the buffer is filled with the original value.

Source files
------------

// File: rtl/frame_buffer_clr.sv
// Dual-port frame buffer: port A read/write, port B read-only scan-out,
// plus a clear engine that fills every word with a latched value.
//
// state   | meaning
// S_IDLE  | ports A and B active, waiting for clr_start_i
// S_CLEAR | one fill word written per cycle, port A locked out
module frame_buffer_clr #(
  parameter int DATA_WIDTH  = 1,
  parameter int ADDR_WIDTH  = 15,
  parameter int DEPTH       = 2**ADDR_WIDTH,
  parameter int WRITE_FIRST = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  input  logic                  a_we_i,
  input  logic                  a_en_i,
  output logic [DATA_WIDTH-1:0] a_data_o,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic                  b_en_i,
  output logic [DATA_WIDTH-1:0] b_data_o,
  output logic                  b_valid_o,
  input  logic                  clr_start_i,
  input  logic [DATA_WIDTH-1:0] clr_value_i,
  output logic                  busy_o,
  output logic                  clr_done_o
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH-1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  logic                  clr_done_q, clr_done_d;
  logic [DATA_WIDTH-1:0] a_data_q, a_data_d;
  logic [DATA_WIDTH-1:0] b_data_q, b_data_d;
  logic                  b_valid_q, b_valid_d;

  logic busy;
  logic a_in_range, b_in_range;
  logic a_acc, a_wr;

  assign busy       = (state_q == S_CLEAR);
  assign a_in_range = ({1'b0, a_addr_i} < DEPTH_W);
  assign b_in_range = ({1'b0, b_addr_i} < DEPTH_W);
  assign a_acc      = a_en_i & ~busy;
  // a write coinciding with a clear request loses to the clear
  assign a_wr       = a_acc & a_we_i & ~clr_start_i & a_in_range;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      fill_q     <= '0;
      clr_done_q <= 1'b0;
      a_data_q   <= '0;
      b_data_q   <= '0;
      b_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      clr_done_q <= clr_done_d;
      a_data_q   <= a_data_d;
      b_data_q   <= b_data_d;
      b_valid_q  <= b_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    clr_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_start_i) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          fill_d  = clr_value_i;
        end
      end
      S_CLEAR: begin
        if (cnt_q == LAST) begin
          state_d    = S_IDLE;
          clr_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read data is taken from the array before this edge's write lands,
  // so port B is inherently read-first.
  always_comb begin
    a_data_d  = a_data_q;
    b_data_d  = b_data_q;
    b_valid_d = 1'b0;
    if (a_acc) begin
      if (!a_in_range)
        a_data_d = '0;
      else if ((WRITE_FIRST != 0) && a_wr)
        a_data_d = a_data_i;
      else
        a_data_d = mem[a_addr_i];
    end
    if (b_en_i) begin
      b_valid_d = 1'b1;
      b_data_d  = b_in_range ? mem[b_addr_i] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (busy)
      mem[cnt_q] <= fill_q;
    else if (a_wr)
      mem[a_addr_i] <= a_data_i;
  end

  always_comb begin
    busy_o     = busy;
    clr_done_o = clr_done_q;
    a_data_o   = a_data_q;
    b_data_o   = b_data_q;
    b_valid_o  = b_valid_q;
  end

endmodule
